// File: rtl/packet_resolver_if.sv
// Avalon-ST streaming interface used on both sides of packet_resolver.
// The sink modport receives beats, the src modport produces them.
interface avalon_st_if #(
    parameter int DWIDTH        = 64,
    parameter int CHANNEL_WIDTH = 1,
    parameter int EMPTY_WIDTH   = $clog2(DWIDTH / 8)
) ();
    logic [DWIDTH-1:0]        data;
    logic                     valid;
    logic                     ready;
    logic                     startofpacket;
    logic                     endofpacket;
    logic [EMPTY_WIDTH-1:0]   empty;
    logic [CHANNEL_WIDTH-1:0] channel;

    // Handshake: a beat transfers on a rising edge where valid & ready are both 1
    // (ready latency 0); a source holding valid keeps all fields stable until then.
    modport sink (input data, valid, startofpacket, endofpacket, empty, channel,
                  output ready);
    modport src  (output data, valid, startofpacket, endofpacket, empty, channel,
                  input ready);
endinterface

// File: rtl/packet_resolver.sv
// Store-and-forward packet filter. Each incoming packet is written speculatively
// into a circular buffer; the classifier verdict on `channel` at the eop beat
// either commits the packet (read side may see it) or rolls the write pointer
// back so the packet vanishes. Only committed words are ever read out.
module packet_resolver #(
    parameter int AST_DWIDTH    = 64,
    parameter int CHANNEL_WIDTH = 1,
    parameter int FIFO_DEPTH    = 256,
    parameter int EMPTY_WIDTH   = $clog2(AST_DWIDTH / 8)
) (
    input  logic       clk_i,
    input  logic       srst_i,
    avalon_st_if.sink  sink_if,
    avalon_st_if.src   src_if
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam int EW = AST_DWIDTH + 2 + EMPTY_WIDTH;
    localparam logic [PW-1:0] DEPTH_P = PW'(FIFO_DEPTH);
    localparam logic [PW-1:0] ONE_P   = PW'(1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RECV    = 2'd1,
        DISCARD = 2'd2
    } state_t;

    state_t state, state_nxt;

    // Pointers carry a wrap bit so full/empty are distinguishable.
    logic [PW-1:0] wr_ptr, wr_ptr_nxt;
    logic [PW-1:0] commit_ptr, commit_ptr_nxt;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] base_ptr;
    logic [PW-1:0] len_after;

    logic [EW-1:0] mem [FIFO_DEPTH];
    logic [EW-1:0] wr_word;
    logic [EW-1:0] out_word;
    logic [AW-1:0] wr_addr;
    logic          wr_en;
    logic          full;
    logic          in_ready;
    logic          accept;
    logic          match;
    logic          sop;
    logic          eop;
    logic          out_valid;
    logic          fetch;

    assign full      = (wr_ptr - rd_ptr) == DEPTH_P;
    assign accept    = sink_if.valid & in_ready;
    assign match     = |sink_if.channel;
    assign sop       = sink_if.startofpacket;
    assign eop       = sink_if.endofpacket;
    assign wr_word   = {sink_if.data, sop, eop, sink_if.empty};
    // A sop always starts at the last commit point, which also aborts any open packet.
    assign base_ptr  = sop ? commit_ptr : wr_ptr;
    assign len_after = wr_ptr + ONE_P - commit_ptr;

    // Sink ready: low in reset; writing states stall on a full buffer, DISCARD never stalls.
    always_comb begin
        in_ready = 1'b0;
        if (!srst_i) begin
            if (state == DISCARD) in_ready = 1'b1;
            else                  in_ready = !full;
        end
    end

    assign sink_if.ready = in_ready;

    // Input FSM next-state, pointer updates and buffer write control.
    always_comb begin
        state_nxt      = state;
        wr_ptr_nxt     = wr_ptr;
        commit_ptr_nxt = commit_ptr;
        wr_en          = 1'b0;
        wr_addr        = base_ptr[AW-1:0];
        if (accept) begin
            case (state)
                IDLE, RECV: begin
                    if (state == IDLE && !sop) begin
                        // stray beat outside a packet: dropped
                        state_nxt = IDLE;
                    end else begin
                        wr_en = 1'b1;
                        if (eop) begin
                            if (match) begin
                                commit_ptr_nxt = base_ptr + ONE_P;
                                wr_ptr_nxt     = base_ptr + ONE_P;
                            end else begin
                                wr_ptr_nxt     = commit_ptr;
                            end
                            state_nxt = IDLE;
                        end else if (!sop && len_after == DEPTH_P) begin
                            // packet cannot fit: forget it and swallow the rest
                            wr_ptr_nxt = commit_ptr;
                            state_nxt  = DISCARD;
                        end else begin
                            wr_ptr_nxt = base_ptr + ONE_P;
                            state_nxt  = RECV;
                        end
                    end
                end
                DISCARD: begin
                    if (eop) state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Input FSM state and pointer registers.
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            commit_ptr <= '0;
        end else begin
            state      <= state_nxt;
            wr_ptr     <= wr_ptr_nxt;
            commit_ptr <= commit_ptr_nxt;
        end
    end

    // Buffer write port; in_ready is low during reset so nothing is written then.
    always_ff @(posedge clk_i) begin
        if (wr_en) mem[wr_addr] <= wr_word;
    end

    // Refill the output register from committed words whenever it is free or being consumed.
    assign fetch = (rd_ptr != commit_ptr) && (!out_valid || src_if.ready);

    // Output register doubles as the RAM read register; it holds while stalled.
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            out_valid <= 1'b0;
            out_word  <= '0;
            rd_ptr    <= '0;
        end else if (fetch) begin
            out_word  <= mem[rd_ptr[AW-1:0]];
            out_valid <= 1'b1;
            rd_ptr    <= rd_ptr + ONE_P;
        end else if (src_if.ready) begin
            out_valid <= 1'b0;
        end
    end

    assign src_if.valid         = out_valid;
    assign src_if.data          = out_word[EW-1 -: AST_DWIDTH];
    assign src_if.startofpacket = out_word[EMPTY_WIDTH+1];
    assign src_if.endofpacket   = out_word[EMPTY_WIDTH];
    assign src_if.empty         = out_word[EMPTY_WIDTH-1:0];
    assign src_if.channel       = {CHANNEL_WIDTH{1'b0}};

endmodule
